pulse_checker: RTL and testbench

PULSE_CHECKER -- requirements
Module: pulse_checker

---
 rtl/pulse_pkg.sv | 19 +
 rtl/interval_counter.sv | 38 +++
 rtl/pulse_checker.sv | 119 +++++++++++
 tb/tb_pulse_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse checker: FSM state encoding, counter widths
// and the interval-width helper used to size cnt/MEAS.
package pulse_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int ERR_COUNT_W = 8;
  localparam int GOOD_W      = 4;

  // Must hold 2*PERIOD+1, the largest value of cnt+1.
  function automatic int meas_width(input int period);
    return $clog2(2 * period + 1);
  endfunction

endpackage

// File: rtl/interval_counter.sv
// Counts cycles since IN was last sampled high, saturating at 2*PERIOD.
module interval_counter
  import pulse_pkg::*;
#(
  parameter int PERIOD = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           IN,
  output logic [meas_width(PERIOD)-1:0]  cnt
);

  localparam int W = meas_width(PERIOD);
  localparam logic [W-1:0] CNT_MAX = W'(2 * PERIOD);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (IN) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pulse_checker.sv
// Pulse-interval checker: locks after LOCK_CNT intervals equal to PERIOD and
// strobes ERR on a broken lock or a timeout. PULSE_CHECKER_STATS_EN adds ERR_COUNT.
module pulse_checker
  import pulse_pkg::*;
#(
  parameter int PERIOD   = 5,
  parameter int LOCK_CNT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          IN,
  output logic                          LOCK,
  output logic                          ERR,
`ifdef PULSE_CHECKER_STATS_EN
  output logic [ERR_COUNT_W-1:0]        ERR_COUNT,
`endif
  output logic [meas_width(PERIOD)-1:0] MEAS
);

  localparam int W = meas_width(PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_CNT);

  logic [W-1:0]      cnt;
  logic [W-1:0]      interval;
  logic              pulse_ok;
  logic              timeout;
  logic [GOOD_W-1:0] good_inc;

  state_e            state_q;
  logic [GOOD_W-1:0] good_q;
  logic              lock_q;
  logic              err_q;
  logic [W-1:0]      meas_q;

  interval_counter #(
    .PERIOD (PERIOD)
  ) u_interval_counter (
    .clk   (clk),
    .reset (reset),
    .IN    (IN),
    .cnt   (cnt)
  );

  assign interval = cnt + W'(1);
  assign pulse_ok = (interval == W'(PERIOD));
  assign timeout  = !IN && (interval == W'(2 * PERIOD));
  assign good_inc = good_q + GOOD_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      good_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      meas_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (IN) begin
            state_q <= ACQUIRE;
            good_q  <= '0;
          end
        end
        ACQUIRE, LOCKED: begin
          if (IN) begin
            meas_q <= interval;
            if (state_q == LOCKED) begin
              if (!pulse_ok) begin
                err_q   <= 1'b1;
                lock_q  <= 1'b0;
                state_q <= ACQUIRE;
                good_q  <= '0;
              end
            end else if (pulse_ok) begin
              good_q <= good_inc;
              if (good_inc == GOOD_TARGET) begin
                state_q <= LOCKED;
                lock_q  <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end else if (timeout) begin
            // Stream went quiet: drop back to hunting for a first pulse.
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
            state_q <= SEARCH;
            good_q  <= '0;
          end
        end
        default: begin
          state_q <= SEARCH;
          lock_q  <= 1'b0;
          good_q  <= '0;
        end
      endcase
    end
  end

  assign LOCK = lock_q;
  assign ERR  = err_q;
  assign MEAS = meas_q;

`ifdef PULSE_CHECKER_STATS_EN
  logic [ERR_COUNT_W-1:0] err_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
    end else if (err_q && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_COUNT_W'(1);
    end
  end

  assign ERR_COUNT = err_count_q;
`endif

endmodule

// File: tb/tb_pulse_checker.sv
// Randomised and directed bench for pulse_checker against a behavioural model
// of interval/lock rules; define PULSE_CHECKER_STATS_EN to also cover ERR_COUNT.
module tb_pulse_checker;

  localparam int PERIOD   = 5;
  localparam int LOCK_CNT = 3;
  localparam int W        = $clog2(2 * PERIOD + 1);

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         IN    = 1'b0;
  logic         LOCK;
  logic         ERR;
  logic [W-1:0] MEAS;
`ifdef PULSE_CHECKER_STATS_EN
  logic [7:0]   ERR_COUNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  // Behavioural model: tracking = a first pulse has been seen, gap = low
  // samples since the last pulse, run = consecutive good intervals.
  bit m_track;
  bit m_lock;
  bit m_err;
  int m_run;
  int m_gap;
  int m_meas;
  int m_ecount;

  int gap_table[10] = '{5, 5, 5, 5, 4, 6, 1, 2, 10, 12};

  pulse_checker #(
    .PERIOD   (PERIOD),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IN        (IN),
    .LOCK      (LOCK),
    .ERR       (ERR),
`ifdef PULSE_CHECKER_STATS_EN
    .ERR_COUNT (ERR_COUNT),
`endif
    .MEAS      (MEAS)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_track  = 1'b0;
    m_lock   = 1'b0;
    m_err    = 1'b0;
    m_run    = 0;
    m_gap    = 0;
    m_meas   = 0;
    m_ecount = 0;
  endtask

  task automatic model_edge(input bit in_v);
    int ivl;
    ivl = m_gap + 1;
    if (m_err && m_ecount < 255) m_ecount++;
    m_err = 1'b0;
    if (in_v) begin
      if (!m_track) begin
        m_track = 1'b1;
        m_run   = 0;
      end else begin
        m_meas = ivl;
        if (ivl == PERIOD) begin
          if (!m_lock) begin
            m_run++;
            if (m_run >= LOCK_CNT) m_lock = 1'b1;
          end
        end else begin
          if (m_lock) m_err = 1'b1;
          m_lock = 1'b0;
          m_run  = 0;
        end
      end
      m_gap = 0;
    end else begin
      if (m_track && ivl == 2 * PERIOD) begin
        m_err   = 1'b1;
        m_lock  = 1'b0;
        m_track = 1'b0;
      end
      if (m_gap < 2 * PERIOD) m_gap++;
    end
  endtask

  task automatic check_outputs();
    check_val("LOCK", LOCK, m_lock);
    check_val("ERR", ERR, m_err);
    check_val("MEAS", MEAS, m_meas);
`ifdef PULSE_CHECKER_STATS_EN
    check_val("ERR_COUNT", ERR_COUNT, m_ecount);
`endif
    if (ERR === 1'b1) err_seen++;
  endtask

  task automatic cycle(input bit v);
    @(negedge clk);
    IN = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check_outputs();
  endtask

  // gap-1 low samples followed by one high sample: interval of 'gap'.
  task automatic pulse_after(input int gap);
    for (int i = 0; i < gap - 1; i++) cycle(1'b0);
    cycle(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_LOCK", LOCK, 0);
    check_val("rst_ERR", ERR, 0);
    check_val("rst_MEAS", MEAS, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("scenario: periodic stream locks");
    for (int p = 1; p <= 4; p++) begin
      pulse_after(PERIOD);
      if (p == 3) check_val("lock_before_4th", LOCK, 0);
    end
    check_val("lock_after_4th", LOCK, 1);
    check_val("meas_locked", MEAS, PERIOD);
    pulse_after(PERIOD);
    pulse_after(PERIOD);
    check_val("no_err_periodic", err_seen, 0);

    $display("scenario: short interval breaks lock, then relock");
    err_seen = 0;
    pulse_after(4);
    check_val("short_ERR", ERR, 1);
    check_val("short_LOCK", LOCK, 0);
    check_val("short_MEAS", MEAS, 4);
    for (int p = 0; p < 3; p++) pulse_after(PERIOD);
    check_val("relock_LOCK", LOCK, 1);
    check_val("short_err_once", err_seen, 1);

    $display("scenario: stream stops, timeout");
    err_seen = 0;
    for (int i = 0; i < 25; i++) cycle(1'b0);
    check_val("timeout_err_once", err_seen, 1);
    check_val("timeout_LOCK", LOCK, 0);

    $display("scenario: IN held high in ACQUIRE");
    err_seen = 0;
    cycle(1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check_val("held_MEAS", MEAS, 1);
    check_val("held_LOCK", LOCK, 0);
    check_val("held_no_err", err_seen, 0);

    $display("scenario: random intervals");
    for (int p = 0; p < 150; p++) pulse_after(gap_table[$urandom_range(0, 9)]);

    $display("scenario: random bit stream");
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 2) == 0);

    $display("scenario: async reset while locked");
    for (int p = 0; p < 4; p++) pulse_after(PERIOD);
    check_val("pre_reset_LOCK", LOCK, 1);
    cycle(1'b0);
    cycle(1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_val("async_LOCK", LOCK, 0);
    check_val("async_ERR", ERR, 0);
    check_val("async_MEAS", MEAS, 0);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1);
    pulse_after(PERIOD);
    pulse_after(PERIOD);
    check_val("relock_not_yet", LOCK, 0);
    pulse_after(PERIOD);
    check_val("relock_after_reset", LOCK, 1);

`ifdef PULSE_CHECKER_STATS_EN
    $display("scenario: error counter saturation");
    for (int e = 0; e < 300; e++) begin
      cycle(1'b1);
      for (int i = 0; i < 2 * PERIOD; i++) cycle(1'b0);
    end
    cycle(1'b0);
    check_val("err_count_sat", ERR_COUNT, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
